// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Holds the PC, presents it as the byte address to a
// combinational instruction memory and pushes each returned {pc, ins} pair into
// a 2-entry FIFO that feeds decode over a valid/ready handshake. A redirect from
// EX flushes the FIFO and restarts fetch at the (word-aligned) target.
//
// Parameters
//   RESET_PC  PC loaded on reset (bits [1:0] expected to be zero)
//   CNT_W     width of the accepted-instruction counter
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   imem_addr       byte address to instruction memory (the PC register)
//   imem_ins        instruction word returned in the same cycle
//   redirect_valid  EX requests a PC change
//   redirect_pc     redirect target, low two bits ignored
//   out_valid       FIFO head holds an instruction
//   out_ready       decode accepts the head this cycle
//   out_pc/out_ins  head instruction PC and word
//   out_npc         out_pc + 4
//   fetch_cnt       number of instructions accepted by decode (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_ins,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_ins,
   output logic [31:0]      out_npc,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [1:0] {
      StBoot,
      StFetch,
      StStall
   } state_e;

   state_e           state_q,    state_d;
   logic [31:0]      pc_q,       pc_d;
   logic [1:0]       cnt_q,      cnt_d;
   // The head entry doubles as the registered output, so out_* never depend
   // combinationally on inputs.
   logic [31:0]      head_pc_q,  head_pc_d;
   logic [31:0]      head_ins_q, head_ins_d;
   logic [31:0]      head_npc_q, head_npc_d;
   logic [31:0]      tail_pc_q,  tail_pc_d;
   logic [31:0]      tail_ins_q, tail_ins_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

   logic        pop;
   logic        push;
   logic [31:0] pc_plus4;
   logic [31:0] tail_npc;

   assign pc_plus4 = pc_q + 32'd4;
   assign tail_npc = tail_pc_q + 32'd4;

   assign pop  = (cnt_q != 2'd0) & out_ready;
   // A full FIFO may still take a new entry when the head leaves on the same edge.
   assign push = (state_q == StFetch) & ~redirect_valid & ((cnt_q != 2'd2) | pop);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      head_pc_d   = head_pc_q;
      head_ins_d  = head_ins_q;
      head_npc_d  = head_npc_q;
      tail_pc_d   = tail_pc_q;
      tail_ins_d  = tail_ins_q;
      fetch_cnt_d = fetch_cnt_q;

      // A pop on a redirect edge still reached decode, so it is counted.
      if (pop) begin
         fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end

      if (redirect_valid) begin
         // Head registers keep their stale values; out_valid drops via cnt.
         state_d = StFetch;
         cnt_d   = 2'd0;
         pc_d    = {redirect_pc[31:2], 2'b00};
      end else begin
         unique case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: state_d = StFetch;
            StStall: if (pop) state_d = StFetch;
            default: state_d = StBoot;
         endcase

         if (push) begin
            pc_d = pc_plus4;
         end

         case ({pop, push})
            2'b10: begin
               cnt_d = cnt_q - 2'd1;
               if (cnt_q == 2'd2) begin
                  head_pc_d  = tail_pc_q;
                  head_ins_d = tail_ins_q;
                  head_npc_d = tail_npc;
               end
            end
            2'b01: begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd0) begin
                  head_pc_d  = pc_q;
                  head_ins_d = imem_ins;
                  head_npc_d = pc_plus4;
               end else begin
                  tail_pc_d  = pc_q;
                  tail_ins_d = imem_ins;
               end
            end
            2'b11: begin
               // Count unchanged; shift the tail forward when full to keep order.
               if (cnt_q == 2'd2) begin
                  head_pc_d  = tail_pc_q;
                  head_ins_d = tail_ins_q;
                  head_npc_d = tail_npc;
                  tail_pc_d  = pc_q;
                  tail_ins_d = imem_ins;
               end else begin
                  head_pc_d  = pc_q;
                  head_ins_d = imem_ins;
                  head_npc_d = pc_plus4;
               end
            end
            default: ;
         endcase

         if ((state_q == StFetch) && (cnt_d == 2'd2)) begin
            state_d = StStall;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StBoot;
         pc_q        <= RESET_PC;
         cnt_q       <= 2'd0;
         head_pc_q   <= 32'd0;
         head_ins_q  <= 32'd0;
         head_npc_q  <= 32'd0;
         tail_pc_q   <= 32'd0;
         tail_ins_q  <= 32'd0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         head_pc_q   <= head_pc_d;
         head_ins_q  <= head_ins_d;
         head_npc_q  <= head_npc_d;
         tail_pc_q   <= tail_pc_d;
         tail_ins_q  <= tail_ins_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (cnt_q != 2'd0);
   assign out_pc    = head_pc_q;
   assign out_ins   = head_ins_q;
   assign out_npc   = head_npc_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Two fetch_stage instances (RESET_PC = 0 and RESET_PC = 32'hFFFF_FFF8) share
// the same stimulus. Each is compared every cycle against a queue-based model
// of the fetch/decode handshake. Memory word at byte address A is A >> 2.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic [31:0] imem_addr [2];
   logic [31:0] imem_ins  [2];
   logic        out_valid [2];
   logic [31:0] out_pc    [2];
   logic [31:0] out_ins   [2];
   logic [31:0] out_npc   [2];
   logic [31:0] fetch_cnt [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr >> 2;
   endfunction

   function automatic logic [31:0] reset_pc(input int i);
      return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
   endfunction

   assign imem_ins[0] = mem_word(imem_addr[0]);
   assign imem_ins[1] = mem_word(imem_addr[1]);

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (32)
   ) u_dut0 (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr[0]),
      .imem_ins       (imem_ins[0]),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid[0]),
      .out_ready      (out_ready),
      .out_pc         (out_pc[0]),
      .out_ins        (out_ins[0]),
      .out_npc        (out_npc[0]),
      .fetch_cnt      (fetch_cnt[0])
   );

   fetch_stage #(
      .RESET_PC (32'hFFFF_FFF8),
      .CNT_W    (32)
   ) u_dut1 (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr[1]),
      .imem_ins       (imem_ins[1]),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid[1]),
      .out_ready      (out_ready),
      .out_pc         (out_pc[1]),
      .out_ins        (out_ins[1]),
      .out_npc        (out_npc[1]),
      .fetch_cnt      (fetch_cnt[1])
   );

   // Reference model: queue of {pc, ins} pairs seen by decode.
   logic [63:0] m_q [2][$];
   logic [31:0] m_pc       [2];
   logic [31:0] m_cnt      [2];
   logic [31:0] m_last_pc  [2];
   logic [31:0] m_last_ins [2];
   logic [31:0] m_last_npc [2];
   bit          m_booted   [2];
   bit          m_stalled  [2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_q[i].delete();
         m_pc[i]       = reset_pc(i);
         m_cnt[i]      = 0;
         m_last_pc[i]  = 0;
         m_last_ins[i] = 0;
         m_last_npc[i] = 0;
         m_booted[i]   = 0;
         m_stalled[i]  = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs present before it.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit pop;
         bit do_push;
         pop = (m_q[i].size() > 0) && out_ready;
         if (pop) m_cnt[i] = m_cnt[i] + 1;
         if (redirect_valid) begin
            m_q[i].delete();
            m_pc[i]      = {redirect_pc[31:2], 2'b00};
            m_booted[i]  = 1;
            m_stalled[i] = 0;
         end else if (!m_booted[i]) begin
            m_booted[i] = 1;
         end else begin
            do_push = !m_stalled[i] && ((m_q[i].size() < 2) || pop);
            if (pop) void'(m_q[i].pop_front());
            if (do_push) begin
               m_q[i].push_back({m_pc[i], mem_word(m_pc[i])});
               m_pc[i] = m_pc[i] + 32'd4;
            end
            m_stalled[i] = m_stalled[i] ? !pop : (m_q[i].size() == 2);
         end
         if (m_q[i].size() > 0) begin
            m_last_pc[i]  = m_q[i][0][63:32];
            m_last_ins[i] = m_q[i][0][31:0];
            m_last_npc[i] = m_q[i][0][63:32] + 32'd4;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("d%0d_valid", i), {31'd0, out_valid[i]},
                  {31'd0, (m_q[i].size() > 0)});
         check_eq($sformatf("d%0d_imem_addr", i), imem_addr[i], m_pc[i]);
         check_eq($sformatf("d%0d_out_pc", i), out_pc[i], m_last_pc[i]);
         check_eq($sformatf("d%0d_out_ins", i), out_ins[i], m_last_ins[i]);
         check_eq($sformatf("d%0d_out_npc", i), out_npc[i], m_last_npc[i]);
         check_eq($sformatf("d%0d_fetch_cnt", i), fetch_cnt[i], m_cnt[i]);
      end
   endtask

   // Called at a negedge; returns at the next negedge after checking.
   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      check_eq("async_valid", {31'd0, out_valid[0]}, 32'd0);
      check_eq("async_cnt", fetch_cnt[0], 32'd0);
      redirect_valid = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      out_ready      = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // Fill with decode stalled: two entries, PC frozen at 8.
      cycles(6);
      check_eq("hold_addr", imem_addr[0], 32'd8);
      check_eq("hold_pc1", out_pc[1], 32'hFFFF_FFF8);
      out_ready = 1'b1;
      cycles(4);
      check_eq("four_pops", fetch_cnt[0], 32'd4);
      cycles(8);

      // Redirect with a full buffer.
      out_ready = 1'b0;
      cycles(3);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      cycle();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      check_eq("flush_valid", {31'd0, out_valid[0]}, 32'd0);
      cycle();
      check_eq("redir_pc", out_pc[0], 32'h40);
      check_eq("redir_ins", out_ins[0], 32'd16);
      cycles(4);

      // Misaligned redirect target.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h43;
      cycle();
      redirect_valid = 1'b0;
      check_eq("align_addr", imem_addr[0], 32'h40);
      cycles(4);

      // Reset mid-stream with two entries buffered.
      out_ready = 1'b0;
      cycles(3);
      do_reset();
      out_ready = 1'b1;
      cycles(2);
      check_eq("restart_pc0", out_pc[0], 32'h0);
      check_eq("restart_pc1", out_pc[1], 32'hFFFF_FFF8);
      cycles(3);

      // Randomised traffic with varying backpressure.
      for (int blk = 0; blk < 15; blk++) begin
         int ready_pct;
         ready_pct = $urandom_range(10, 100);
         for (int k = 0; k < 200; k++) begin
            out_ready      = ($urandom_range(1, 100) <= ready_pct);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom();
            if ($urandom_range(0, 299) == 0) begin
               do_reset();
            end else begin
               cycle();
            end
         end
      end
      redirect_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
